ram_arb_2m: RTL and testbench

- Two-host request arbiter that sits directly upstream of the single-port 32-bit RAM. It merges the core instruction port (host A) and data port (host B) onto the one RAM request port.
- Grants at most one request per cycle and forwards it to the RAM.
- Routes each RAM read response, which arrives exactly 1 cycle later, back to the host that issued the request.
- Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/ram_arb_2m.sv | 145 ++++++++++++++
 tb/tb_ram_arb_2m.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_2m.sv
// Two-host (instruction A / data B) arbiter in front of the single-port 32-bit RAM.
// Define RAM_ARB_ADDR_CHECK_EN to answer out-of-window requests locally with an error response.
module ram_arb_2m #(
    parameter bit          RoundRobin = 1'b1,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int          Depth      = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_req_i,
    output logic        a_gnt_o,
    input  logic        a_we_i,
    input  logic [3:0]  a_be_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    input  logic        b_req_i,
    output logic        b_gnt_o,
    input  logic        b_we_i,
    input  logic [3:0]  b_be_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
`ifdef RAM_ARB_ADDR_CHECK_EN
    output logic        a_err_o,
    output logic        b_err_o,
`endif
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    // Handshake: a host holds req and its fields stable until gnt is seen in the same
    // cycle; every grant yields exactly one rvalid to that host one cycle later.
    typedef enum logic {
        HOST_A = 1'b0,
        HOST_B = 1'b1
    } host_e;

    host_e       last_owner;
    host_e       resp_owner;
    logic        resp_pending;
    logic        a_gnt;
    logic        b_gnt;
    logic        any_gnt;
    logic        fwd;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        resp_vld;
    logic [31:0] resp_data;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst_i) begin
            if (a_req_i && b_req_i) begin
                if (RoundRobin && last_owner == HOST_A) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req_i;
                b_gnt = b_req_i;
            end
        end
    end

    assign a_gnt_o   = a_gnt;
    assign b_gnt_o   = b_gnt;
    assign any_gnt   = a_gnt | b_gnt;
    assign sel_we    = b_gnt ? b_we_i    : a_we_i;
    assign sel_be    = b_gnt ? b_be_i    : a_be_i;
    assign sel_addr  = b_gnt ? b_addr_i  : a_addr_i;
    assign sel_wdata = b_gnt ? b_wdata_i : a_wdata_i;

`ifdef RAM_ARB_ADDR_CHECK_EN
    localparam logic [32:0] WinBytes = 33'(Depth) << 2;

    logic [32:0] win_off;
    logic        in_win;
    logic        resp_err;

    // 33-bit offset: addresses below BaseAddr wrap to a huge value and fail the compare.
    assign win_off = {1'b0, sel_addr} - {1'b0, BaseAddr};
    assign in_win  = win_off < WinBytes;
    assign fwd     = any_gnt & in_win;
`else
    // BaseAddr and Depth only size the address window, which is not built here.
    if (Depth < 1 || BaseAddr[1:0] != 2'b00) begin : g_window_unused
    end
    assign fwd = any_gnt;
`endif

    assign ram_req_o   = fwd;
    assign ram_we_o    = fwd & sel_we;
    assign ram_be_o    = fwd ? sel_be    : 4'h0;
    assign ram_addr_o  = fwd ? sel_addr  : 32'h0;
    assign ram_wdata_o = fwd ? sel_wdata : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner   <= HOST_B;
            resp_owner   <= HOST_A;
            resp_pending <= 1'b0;
`ifdef RAM_ARB_ADDR_CHECK_EN
            resp_err     <= 1'b0;
`endif
        end else begin
            resp_pending <= any_gnt;
            if (any_gnt) begin
                last_owner <= b_gnt ? HOST_B : HOST_A;
                resp_owner <= b_gnt ? HOST_B : HOST_A;
`ifdef RAM_ARB_ADDR_CHECK_EN
                resp_err   <= ~in_win;
`endif
            end
        end
    end

    // Gating with rst_i drops a response that was in flight when reset arrived.
`ifdef RAM_ARB_ADDR_CHECK_EN
    assign resp_vld  = resp_pending & ~rst_i & (ram_rvalid_i | resp_err);
    assign resp_data = resp_err ? 32'hBADC_AB1E : ram_rdata_i;
    assign a_err_o   = a_rvalid_o & resp_err;
    assign b_err_o   = b_rvalid_o & resp_err;
`else
    assign resp_vld  = resp_pending & ~rst_i & ram_rvalid_i;
    assign resp_data = ram_rdata_i;
`endif

    assign a_rvalid_o = resp_vld & (resp_owner == HOST_A);
    assign b_rvalid_o = resp_vld & (resp_owner == HOST_B);
    assign a_rdata_o  = a_rvalid_o ? resp_data : 32'h0;
    assign b_rdata_o  = b_rvalid_o ? resp_data : 32'h0;

endmodule

// File: tb/tb_ram_arb_2m.sv
// Bench for ram_arb_2m: a round-robin and a fixed-priority instance share host stimulus.
// Each instance has its own small RAM model; responses are checked through expected queues.
module tb_ram_arb_2m;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef RAM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam logic [36:0] IDLE_E = 37'h1_0000_0000;

  // shared host stimulus
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  a_be = 4'h0, b_be = 4'h0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        spur = 1'b0;

  // round-robin instance
  logic        rr_a_gnt, rr_b_gnt, rr_a_rv, rr_b_rv, rr_a_err, rr_b_err;
  logic [31:0] rr_a_rd, rr_b_rd;
  logic        rr_ram_req, rr_ram_we, rr_ram_rv;
  logic [3:0]  rr_ram_be;
  logic [31:0] rr_ram_addr, rr_ram_wdata, rr_ram_rd;
  logic        rr_ram_rv_q = 1'b0;
  // fixed-priority instance
  logic        fp_a_gnt, fp_b_gnt, fp_a_rv, fp_b_rv, fp_a_err, fp_b_err;
  logic [31:0] fp_a_rd, fp_b_rd;
  logic        fp_ram_req, fp_ram_we, fp_ram_rv;
  logic [3:0]  fp_ram_be;
  logic [31:0] fp_ram_addr, fp_ram_wdata, fp_ram_rd;

  ram_arb_2m #(.RoundRobin(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(rr_a_gnt), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(rr_a_rv), .a_rdata_o(rr_a_rd),
    .b_req_i(b_req), .b_gnt_o(rr_b_gnt), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(rr_b_rv), .b_rdata_o(rr_b_rd),
    .ram_req_o(rr_ram_req), .ram_we_o(rr_ram_we), .ram_be_o(rr_ram_be),
    .ram_addr_o(rr_ram_addr), .ram_wdata_o(rr_ram_wdata),
`ifdef RAM_ARB_ADDR_CHECK_EN
    .a_err_o(rr_a_err), .b_err_o(rr_b_err),
`endif
    .ram_rvalid_i(rr_ram_rv), .ram_rdata_i(rr_ram_rd)
  );

  ram_arb_2m #(.RoundRobin(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(fp_a_gnt), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(fp_a_rv), .a_rdata_o(fp_a_rd),
    .b_req_i(b_req), .b_gnt_o(fp_b_gnt), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(fp_b_rv), .b_rdata_o(fp_b_rd),
    .ram_req_o(fp_ram_req), .ram_we_o(fp_ram_we), .ram_be_o(fp_ram_be),
    .ram_addr_o(fp_ram_addr), .ram_wdata_o(fp_ram_wdata),
`ifdef RAM_ARB_ADDR_CHECK_EN
    .a_err_o(fp_a_err), .b_err_o(fp_b_err),
`endif
    .ram_rvalid_i(fp_ram_rv), .ram_rdata_i(fp_ram_rd)
  );

`ifndef RAM_ARB_ADDR_CHECK_EN
  assign rr_a_err = 1'b0;
  assign rr_b_err = 1'b0;
  assign fp_a_err = 1'b0;
  assign fp_b_err = 1'b0;
`endif

  // RAM models: a real 128-word memory behind rr, an address echo behind fp
  logic [31:0] mem [0:127];
  logic [31:0] ref_mem [0:127];

  always @(posedge clk) begin
    rr_ram_rv_q <= rr_ram_req;
    if (rr_ram_req) begin
      if (rr_ram_we) begin
        for (int i = 0; i < 4; i++)
          if (rr_ram_be[i]) mem[rr_ram_addr[8:2]][8*i +: 8] <= rr_ram_wdata[8*i +: 8];
        rr_ram_rd <= 32'h0;
      end else begin
        rr_ram_rd <= mem[rr_ram_addr[8:2]];
      end
    end
  end
  assign rr_ram_rv = rr_ram_rv_q | spur;

  logic fp_rv_q = 1'b0;
  always @(posedge clk) begin
    fp_rv_q   <= fp_ram_req;
    fp_ram_rd <= fp_ram_addr;
  end
  assign fp_ram_rv = fp_rv_q;

  // ---------------- scoreboard ----------------
  // entry: {rv_a, rv_b, err_a, err_b, check_data, data}
  logic [36:0] rr_q[$];
  logic [36:0] fp_q[$];
  int checks = 0;
  int failures = 0;
  logic model_last_b = 1'b1;

  typedef struct {
    logic        ar, aw;
    logic [3:0]  abe;
    logic [31:0] aad, awd;
    logic        br, bw;
    logic [3:0]  bbe;
    logic [31:0] bad, bwd;
    logic [1:0]  exp_rr, exp_fp;
  } vec_t;

  function automatic vec_t mk(input logic ar, aw, input logic [3:0] abe, input logic [31:0] aad, awd,
                              input logic br, bw, input logic [3:0] bbe, input logic [31:0] bad, bwd,
                              input logic [1:0] exp_rr, exp_fp);
    vec_t v;
    v.ar = ar; v.aw = aw; v.abe = abe; v.aad = aad; v.awd = awd;
    v.br = br; v.bw = bw; v.bbe = bbe; v.bad = bad; v.bwd = bwd;
    v.exp_rr = exp_rr; v.exp_fp = exp_fp;
    return v;
  endfunction

  function automatic logic in_rng(input logic [31:0] ad);
    return (ad < 32'd512) || !ADDR_CHECK;
  endfunction

  task automatic check(input string nm, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic pick(input vec_t v, input logic [1:0] g, output logic gs, output logic gw,
                      output logic [3:0] gbe, output logic [31:0] gad, output logic [31:0] gwd);
    gs  = (g == 2'b01);
    gw  = gs ? v.bw  : v.aw;
    gbe = gs ? v.bbe : v.abe;
    gad = gs ? v.bad : v.aad;
    gwd = gs ? v.bwd : v.awd;
  endtask

  // ---------------- driver ----------------
  task automatic step(input vec_t v);
    logic gs, gw, ok;
    logic [3:0] gbe;
    logic [31:0] gad, gwd;
    logic [69:0] ef;
    logic [36:0] e;
    @(negedge clk);
    a_req = v.ar; a_we = v.aw; a_be = v.abe; a_addr = v.aad; a_wdata = v.awd;
    b_req = v.br; b_we = v.bw; b_be = v.bbe; b_addr = v.bad; b_wdata = v.bwd;
    #1;
    check("rr_gnt", 70'({rr_a_gnt, rr_b_gnt}), 70'(v.exp_rr));
    check("fp_gnt", 70'({fp_a_gnt, fp_b_gnt}), 70'(v.exp_fp));

    pick(v, v.exp_rr, gs, gw, gbe, gad, gwd);
    ok = in_rng(gad);
    ef = (v.exp_rr != 2'b00 && ok) ? {1'b1, gw, gbe, gad, gwd} : 70'h0;
    check("rr_fwd", {rr_ram_req, rr_ram_we, rr_ram_be, rr_ram_addr, rr_ram_wdata}, ef);
    if (v.exp_rr == 2'b00) begin
      e = IDLE_E;
    end else begin
      e = {!gs, gs, !ok && !gs, !ok && gs, !gw || !ok,
           !ok ? 32'hBADC_AB1E : (gw ? 32'h0 : ref_mem[gad[8:2]])};
      if (gw && ok)
        for (int i = 0; i < 4; i++)
          if (gbe[i]) ref_mem[gad[8:2]][8*i +: 8] = gwd[8*i +: 8];
      model_last_b = gs;
    end
    rr_q.push_back(e);

    pick(v, v.exp_fp, gs, gw, gbe, gad, gwd);
    ok = in_rng(gad);
    ef = (v.exp_fp != 2'b00 && ok) ? {1'b1, gw, gbe, gad, gwd} : 70'h0;
    check("fp_fwd", {fp_ram_req, fp_ram_we, fp_ram_be, fp_ram_addr, fp_ram_wdata}, ef);
    if (v.exp_fp == 2'b00) e = IDLE_E;
    else e = {!gs, gs, !ok && !gs, !ok && gs, !gw || !ok, !ok ? 32'hBADC_AB1E : gad};
    fp_q.push_back(e);
  endtask

  // ---------------- response monitor ----------------
  task automatic cmp_resp(input string nm, input logic [36:0] e, input logic rva, rvb, ea, eb,
                          input logic [31:0] rda, rdb);
    logic [67:0] got, exp, mask;
    got  = {rva, rvb, ea, eb, rda, rdb};
    exp  = {e[36], e[35], e[34], e[33], e[36] ? e[31:0] : 32'h0, e[35] ? e[31:0] : 32'h0};
    mask = {4'hF, (e[32] || !e[36]) ? 32'hFFFF_FFFF : 32'h0,
                  (e[32] || !e[35]) ? 32'hFFFF_FFFF : 32'h0};
    check(nm, 70'(got & mask), 70'(exp & mask));
  endtask

  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #2;
      e = (rr_q.size() != 0) ? rr_q.pop_front() : IDLE_E;
      cmp_resp("rr_resp", e, rr_a_rv, rr_b_rv, rr_a_err, rr_b_err, rr_a_rd, rr_b_rd);
      e = (fp_q.size() != 0) ? fp_q.pop_front() : IDLE_E;
      cmp_resp("fp_resp", e, fp_a_rv, fp_b_rv, fp_a_err, fp_b_err, fp_a_rd, fp_b_rd);
    end
  end

  // ---------------- test ----------------
  vec_t tbl[15];
  vec_t idle;
  vec_t rv;
  logic hold_a = 1'b0, hold_b = 1'b0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'h5A00_0000 | 32'(i);
    end
    mem[4] = 32'h1234_5678;
    mem[5] = 32'hCAFE_0005;
    mem[8] = 32'h0;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    idle    = mk(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00);
    tbl[0]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0, 2'b10, 2'b10);
    tbl[1]  = mk(0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b01);
    tbl[2]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b10, 2'b10);
    tbl[3]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b10);
    tbl[4]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b10, 2'b10);
    tbl[5]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b10);
    tbl[6]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b10, 2'b10);
    tbl[7]  = mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b10);
    tbl[8]  = mk(0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b01);
    tbl[9]  = idle;
    tbl[10] = mk(0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 4'b0011, 32'h20, 32'hAABB_CCDD, 2'b01, 2'b01);
    tbl[11] = mk(1, 0, 4'hF, 32'h20, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0, 2'b10, 2'b10);
    tbl[12] = mk(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0, 2'b01, 2'b10);
    tbl[13] = mk(1, 1, 4'hF, 32'h24, 32'h1122_3344, 1, 0, 4'hF, 32'h24, 32'h0, 2'b10, 2'b10);
    tbl[14] = mk(0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 4'hF, 32'h24, 32'h0, 2'b01, 2'b01);

    // reset; the monitor expects silent rvalid/rdata throughout
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_last_b = 1'b1;

    for (int i = 0; i < 15; i++) step(tbl[i]);
    step(idle);

    // spurious ram_rvalid_i with nothing pending
    spur = 1'b1;
    step(idle);
    spur = 1'b0;
    step(idle);

    // reset one cycle after a grant: the in-flight response must vanish
    step(tbl[0]);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rr_q.delete();
    fp_q.delete();
    step(mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_last_b = 1'b1;
    step(mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b10, 2'b10));
    step(mk(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0, 2'b01, 2'b10));
    step(idle);

`ifdef RAM_ARB_ADDR_CHECK_EN
    // out-of-window read from B is answered locally with an error
    step(mk(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 2'b01, 2'b01));
    step(idle);
`endif

    // random traffic; an ungranted host keeps its request and fields
    rv = idle;
    for (int n = 0; n < 40; n++) begin
      if (!hold_a) begin
        rv.ar  = 1'($urandom_range(0, 1));
        rv.aw  = ($urandom_range(0, 2) == 0);
        rv.abe = 4'($urandom_range(1, 15));
        rv.aad = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
        rv.awd = $urandom;
      end
      if (!hold_b) begin
        rv.br  = 1'($urandom_range(0, 1));
        rv.bw  = ($urandom_range(0, 2) == 0);
        rv.bbe = 4'($urandom_range(1, 15));
        rv.bad = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
        rv.bwd = $urandom;
      end
      if (rv.ar && rv.br) rv.exp_rr = model_last_b ? 2'b10 : 2'b01;
      else rv.exp_rr = {rv.ar, rv.br};
      rv.exp_fp = (rv.ar && rv.br) ? 2'b10 : {rv.ar, rv.br};
      hold_a = rv.ar && !rv.exp_rr[1];
      hold_b = rv.br && !rv.exp_rr[0];
      step(rv);
    end
    step(idle);

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
